cpu_dmem_if: RTL and testbench
==============================

# cpu_dmem_if

Data-memory interface for the CPU pipeline. It captures load/store requests as the instruction leaves p3, runs a single-outstanding request/response transaction on the data bus, and formats load data. Toward the completion logic in p4 it drives `p4_read_pending`, `p4_write_pending` and `p4_mem_rdata`: it is the producer side of the pending/data handshake that p4 consumes to stall and write back.

## Interface
- No parameters. Op encodings (`OP_LDB`, `OP_LDH`, `OP_LDW`, `OP_LDBU`, `OP_LDHU`, `OP_STB`, `OP_STH`, `OP_STW`) come from `cpu.vh`.
- `clock`  in  1  single clock; all state on rising edge
- `reset`  in  1  asynchronous, active-high
- `p3_op`  in  6  op of instruction currently in p3
- `p3_addr`  in  32  effective byte address computed in p3
- `p3_wdata`  in  32  store data (low bits significant for STB/STH)
- `stall`  in  1  global pipeline stall; p3 advances to p4 on a cycle with `stall`=0
- `dmem_request`  out  1  bus request valid
- `dmem_write`  out  1  1 = write, 0 = read
- `dmem_addr`  out  32  word address, bits [1:0] always 0
- `dmem_wdata`  out  32  lane-replicated write data
- `dmem_wstrb`  out  4  byte enables (bit n = byte lane n); 0 for reads
- `dmem_ready`  in  1  bus accepts request this cycle
- `dmem_rvalid`  in  1  read data valid this cycle
- `dmem_rdata`  in  32  raw read word
- `p4_mem_rdata`  out  32  formatted load result, registered
- `p4_read_pending`  out  1  load in p4 not yet complete
- `p4_write_pending`  out  1  store in p4 not yet accepted
- `p4_misaligned`  out  1  p4 memory op is misaligned; no bus access made

## Operation
- Launch: a cycle with `stall`=0 and a memory op in `p3_op`. On launch, the block registers op, byte offset, word address, and lane-formatted wdata/wstrb.
- Alignment: LDH/LDHU/STH require `addr[0]`=0. LDW/STW require `addr[1:0]`=0.
- A misaligned launch sets `p4_misaligned`=1, keeps both pendings 0 and `dmem_request` 0, and sets `p4_mem_rdata`=0.
- Store formatting (little-endian):
  - STB: wdata={4{b}}, wstrb=1<<addr[1:0].
  - STH: wdata={2{h}}, wstrb=addr[1]?1100:0011.
  - STW: wstrb=1111.
- Load formatting:
  - LDB/LDBU take byte lane addr[1:0], sign- or zero-extended.
  - LDH/LDHU take half lane addr[1], sign- or zero-extended.
  - LDW takes the full word.
- FSM states: IDLE, REQ, WAIT_R, DONE.
  - IDLE/DONE, launch with aligned op: go to REQ.
  - IDLE/DONE, launch with non-memory op or misaligned op: go to DONE for a misaligned op, otherwise IDLE.
  - IDLE/DONE, no launch: hold.
  - REQ: `dmem_request`=1 held stable until `dmem_ready`. With ready, a read goes to WAIT_R and a write goes to DONE.
  - WAIT_R: on `dmem_rvalid`, capture the formatted data into `p4_mem_rdata` and go to DONE.
- `p4_read_pending` = (REQ or WAIT_R) and op is a load.
- `p4_write_pending` = REQ and op is a store.
- `p4_mem_rdata` holds its value until the next load captures data.
- `dmem_rvalid` is ignored outside WAIT_R, including in REQ and after reset.
- Launch on the same cycle that DONE retires (back-to-back): go directly to REQ with the new op.

## Timing
- Reset (async, any state including mid-transaction):
  - FSM goes to IDLE.
  - All outputs return to 0.
  - The bus transaction is abandoned; a late `rvalid` is ignored.
- Cycle L = launch edge. From L+1:
  - `dmem_request`=1.
  - The relevant pending output is 1.
- Store with `dmem_ready` at L+1: `p4_write_pending`=0 at L+2.
- Load with ready at L+1 and rvalid at L+2: `p4_read_pending`=0 and `p4_mem_rdata` valid at L+3. Minimum load stall is 2 cycles.
- A pending output falls in the same cycle that `p4_mem_rdata` becomes valid. p4 may write back combinationally when pending drops.
- Bus outputs are registered and never change while `dmem_request`=1 and `dmem_ready`=0.
- At most one transaction is outstanding. A new request never issues before the previous read's rvalid.

## Test plan
- LDB at addr 0x103, bus word 0x80FF_1234, ready at L+1, rvalid at L+2 -> `dmem_addr`=0x100, wstrb=0. `p4_read_pending` is 1 at L+1..L+2. `p4_mem_rdata`=0xFFFF_FF80 at L+3. Same access as LDBU gives 0x0000_0080.
- STH addr 0x22, wdata 0x1234_ABCD, ready delayed 3 cycles -> wdata=0xABCD_ABCD, wstrb=1100. Request and address held stable throughout. `p4_write_pending` is 1 for 4 cycles, then 0.
- LDW addr 0x41 -> no `dmem_request`, `p4_misaligned`=1, both pendings 0.
- Back-to-back LDW 0x200 then STW 0x204 with `stall` driven from `p4_read_pending` -> the second request issues the cycle after the load's DONE. No overlap of outstanding transactions.
- Reset asserted while in WAIT_R, then rvalid pulsed after release -> all outputs 0 immediately. The rvalid is ignored and `p4_mem_rdata` stays 0.
- Non-memory op launched, with spurious `dmem_rvalid` pulses -> FSM stays IDLE, no request, pendings 0.

Source files
------------

// File: rtl/cpu_dmem_if.sv
// Data-memory interface between p3/p4 and the data bus: one outstanding
// request at a time, little-endian store lane formatting and load extraction.
//
//   state  | meaning
//   -------+----------------------------------------------------------
//   IDLE   | nothing in flight, p4 holds no memory op
//   REQ    | request on the bus, waiting for dmem_ready
//   WAIT_R | read accepted, waiting for dmem_rvalid
//   DONE   | p4 memory op finished (or misaligned, no bus access made)

module cpu_dmem_if (
   input  logic        clock,
   input  logic        reset,
   input  logic [5:0]  p3_op,
   input  logic [31:0] p3_addr,
   input  logic [31:0] p3_wdata,
   input  logic        stall,
   output logic        dmem_request,
   output logic        dmem_write,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_wstrb,
   input  logic        dmem_ready,
   input  logic        dmem_rvalid,
   input  logic [31:0] dmem_rdata,
   output logic [31:0] p4_mem_rdata,
   output logic        p4_read_pending,
   output logic        p4_write_pending,
   output logic        p4_misaligned
);

   // Op encodings shared with the rest of the pipeline.
   localparam logic [5:0] OP_LDB  = 6'h20;
   localparam logic [5:0] OP_LDH  = 6'h21;
   localparam logic [5:0] OP_LDW  = 6'h23;
   localparam logic [5:0] OP_LDBU = 6'h24;
   localparam logic [5:0] OP_LDHU = 6'h25;
   localparam logic [5:0] OP_STB  = 6'h28;
   localparam logic [5:0] OP_STH  = 6'h29;
   localparam logic [5:0] OP_STW  = 6'h2B;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_REQ    = 2'd1,
      ST_WAIT_R = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [5:0]  op_q, op_d;
   logic [1:0]  off_q, off_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  wstrb_q, wstrb_d;
   logic        write_q, write_d;
   logic        req_q, req_d;
   logic        rpend_q, rpend_d;
   logic        wpend_q, wpend_d;
   logic        misalign_q, misalign_d;
   logic [31:0] rdata_q, rdata_d;

   logic        p3_is_load;
   logic        p3_is_store;
   logic [1:0]  p3_size;
   logic        p3_misalign;
   logic [31:0] st_wdata;
   logic [3:0]  st_wstrb;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_fmt;

   always_comb begin
      p3_is_load  = 1'b0;
      p3_is_store = 1'b0;
      p3_size     = SZ_W;
      case (p3_op)
         OP_LDB, OP_LDBU: begin
            p3_is_load = 1'b1;
            p3_size    = SZ_B;
         end
         OP_LDH, OP_LDHU: begin
            p3_is_load = 1'b1;
            p3_size    = SZ_H;
         end
         OP_LDW: begin
            p3_is_load = 1'b1;
            p3_size    = SZ_W;
         end
         OP_STB: begin
            p3_is_store = 1'b1;
            p3_size     = SZ_B;
         end
         OP_STH: begin
            p3_is_store = 1'b1;
            p3_size     = SZ_H;
         end
         OP_STW: begin
            p3_is_store = 1'b1;
            p3_size     = SZ_W;
         end
         default: begin
            p3_is_load  = 1'b0;
            p3_is_store = 1'b0;
         end
      endcase
   end

   always_comb begin
      p3_misalign = 1'b0;
      if (p3_size == SZ_H) begin
         p3_misalign = p3_addr[0];
      end else if (p3_size == SZ_W) begin
         p3_misalign = (p3_addr[1:0] != 2'b00);
      end
   end

   // Store data is replicated into every lane so the strobes alone pick the bytes.
   always_comb begin
      st_wdata = 32'h0;
      st_wstrb = 4'b0000;
      if (p3_is_store) begin
         case (p3_size)
            SZ_B: begin
               st_wdata = {4{p3_wdata[7:0]}};
               st_wstrb = 4'b0001 << p3_addr[1:0];
            end
            SZ_H: begin
               st_wdata = {2{p3_wdata[15:0]}};
               st_wstrb = p3_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
               st_wdata = p3_wdata;
               st_wstrb = 4'b1111;
            end
         endcase
      end
   end

   always_comb begin
      ld_byte = dmem_rdata[{off_q, 3'b000} +: 8];
      ld_half = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
      case (op_q)
         OP_LDB:  ld_fmt = {{24{ld_byte[7]}}, ld_byte};
         OP_LDBU: ld_fmt = {24'h0, ld_byte};
         OP_LDH:  ld_fmt = {{16{ld_half[15]}}, ld_half};
         OP_LDHU: ld_fmt = {16'h0, ld_half};
         default: ld_fmt = dmem_rdata;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      off_d      = off_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      wstrb_d    = wstrb_q;
      write_d    = write_q;
      misalign_d = misalign_q;
      rdata_d    = rdata_q;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (!stall) begin
               if (p3_is_load || p3_is_store) begin
                  op_d       = p3_op;
                  off_d      = p3_addr[1:0];
                  misalign_d = p3_misalign;
                  if (p3_misalign) begin
                     state_d = ST_DONE;
                     rdata_d = 32'h0;
                  end else begin
                     state_d = ST_REQ;
                     addr_d  = {p3_addr[31:2], 2'b00};
                     wdata_d = st_wdata;
                     wstrb_d = st_wstrb;
                     write_d = p3_is_store;
                  end
               end else begin
                  state_d    = ST_IDLE;
                  misalign_d = 1'b0;
               end
            end
         end
         ST_REQ: begin
            if (dmem_ready) begin
               state_d = write_q ? ST_DONE : ST_WAIT_R;
            end
         end
         ST_WAIT_R: begin
            if (dmem_rvalid) begin
               rdata_d = ld_fmt;
               state_d = ST_DONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Handshake outputs are registered from the next state so they line up with it.
      req_d   = (state_d == ST_REQ);
      rpend_d = ((state_d == ST_REQ) || (state_d == ST_WAIT_R)) && !write_d;
      wpend_d = (state_d == ST_REQ) && write_d;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         op_q       <= 6'h0;
         off_q      <= 2'b00;
         addr_q     <= 32'h0;
         wdata_q    <= 32'h0;
         wstrb_q    <= 4'b0000;
         write_q    <= 1'b0;
         req_q      <= 1'b0;
         rpend_q    <= 1'b0;
         wpend_q    <= 1'b0;
         misalign_q <= 1'b0;
         rdata_q    <= 32'h0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         off_q      <= off_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         wstrb_q    <= wstrb_d;
         write_q    <= write_d;
         req_q      <= req_d;
         rpend_q    <= rpend_d;
         wpend_q    <= wpend_d;
         misalign_q <= misalign_d;
         rdata_q    <= rdata_d;
      end
   end

   assign dmem_request     = req_q;
   assign dmem_write       = write_q;
   assign dmem_addr        = addr_q;
   assign dmem_wdata       = wdata_q;
   assign dmem_wstrb       = wstrb_q;
   assign p4_mem_rdata     = rdata_q;
   assign p4_read_pending  = rpend_q;
   assign p4_write_pending = wpend_q;
   assign p4_misaligned    = misalign_q;

endmodule

// File: tb/tb_cpu_dmem_if.sv
// Bench for cpu_dmem_if: scripted bus responder with expected bus requests
// and load results queued at launch and compared when the DUT delivers them.

module tb_cpu_dmem_if;

   localparam logic [5:0] OP_NOP  = 6'h00;
   localparam logic [5:0] OP_LDB  = 6'h20;
   localparam logic [5:0] OP_LDH  = 6'h21;
   localparam logic [5:0] OP_LDW  = 6'h23;
   localparam logic [5:0] OP_LDBU = 6'h24;
   localparam logic [5:0] OP_LDHU = 6'h25;
   localparam logic [5:0] OP_STB  = 6'h28;
   localparam logic [5:0] OP_STH  = 6'h29;
   localparam logic [5:0] OP_STW  = 6'h2B;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic        write;
   } bus_exp_t;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [5:0]  p3_op = OP_NOP;
   logic [31:0] p3_addr = 32'h0;
   logic [31:0] p3_wdata = 32'h0;
   logic        stall;
   logic        stall_drv = 1'b0;
   logic        use_pend = 1'b0;
   logic        dmem_request, dmem_write;
   logic [31:0] dmem_addr, dmem_wdata;
   logic [3:0]  dmem_wstrb;
   logic        dmem_ready = 1'b0;
   logic        dmem_rvalid = 1'b0;
   logic [31:0] dmem_rdata = 32'h0;
   logic [31:0] p4_mem_rdata;
   logic        p4_read_pending, p4_write_pending, p4_misaligned;

   int          vectors = 0;
   int          miscompares = 0;
   bus_exp_t    bus_q[$];
   logic [31:0] data_q[$];
   logic [31:0] exp_last = 32'h0;

   assign stall = stall_drv | (use_pend & p4_read_pending);

   always #5 clock = ~clock;

   cpu_dmem_if dut (
      .clock            (clock),
      .reset            (reset),
      .p3_op            (p3_op),
      .p3_addr          (p3_addr),
      .p3_wdata         (p3_wdata),
      .stall            (stall),
      .dmem_request     (dmem_request),
      .dmem_write       (dmem_write),
      .dmem_addr        (dmem_addr),
      .dmem_wdata       (dmem_wdata),
      .dmem_wstrb       (dmem_wstrb),
      .dmem_ready       (dmem_ready),
      .dmem_rvalid      (dmem_rvalid),
      .dmem_rdata       (dmem_rdata),
      .p4_mem_rdata     (p4_mem_rdata),
      .p4_read_pending  (p4_read_pending),
      .p4_write_pending (p4_write_pending),
      .p4_misaligned    (p4_misaligned)
   );

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      vectors++; if (dmem_request !== 1'b0) begin miscompares++; $display("FAIL rst_req: got %b want 0", dmem_request); end
      vectors++; if ({p4_read_pending, p4_write_pending, p4_misaligned} !== 3'b000) begin miscompares++; $display("FAIL rst_flags: got %b want 000", {p4_read_pending, p4_write_pending, p4_misaligned}); end
      vectors++; if (p4_mem_rdata !== 32'h0) begin miscompares++; $display("FAIL rst_rdata: got %h want 0", p4_mem_rdata); end
      vectors++; if ({dmem_addr, dmem_wdata, dmem_wstrb, dmem_write} !== 69'h0) begin miscompares++; $display("FAIL rst_bus: got %h %h %b %b want zeros", dmem_addr, dmem_wdata, dmem_wstrb, dmem_write); end
      reset = 1'b0;
      exp_last = 32'h0;
      tick();
   endtask

   task automatic test_non_mem_op();
      for (int i = 0; i < 6; i++) begin
         p3_op       = (i % 2 == 0) ? OP_NOP : 6'h3F;
         p3_addr     = 32'h0000_0100 + i;
         stall_drv   = 1'b0;
         dmem_rvalid = (i % 2 == 1);
         dmem_rdata  = 32'hA5A5_0000 | i;
         tick();
         dmem_rvalid = 1'b0;
         vectors++; if (dmem_request !== 1'b0) begin miscompares++; $display("FAIL nonmem_req[%0d]: got %b want 0", i, dmem_request); end
         vectors++; if ({p4_read_pending, p4_write_pending} !== 2'b00) begin miscompares++; $display("FAIL nonmem_pend[%0d]: got %b want 00", i, {p4_read_pending, p4_write_pending}); end
         vectors++; if (p4_mem_rdata !== exp_last) begin miscompares++; $display("FAIL nonmem_rdata[%0d]: got %h want %h", i, p4_mem_rdata, exp_last); end
      end
      p3_op = OP_NOP;
   endtask

   task automatic run_load(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] word,
                           input logic [31:0] exp, input int rdy_d, input int rv_d);
      bus_exp_t be;
      bus_q.push_back('{addr: {addr[31:2], 2'b00}, wdata: 32'h0, wstrb: 4'b0000, write: 1'b0});
      data_q.push_back(exp);
      p3_op     = op;
      p3_addr   = addr;
      p3_wdata  = 32'hDEAD_0000;
      stall_drv = 1'b0;
      tick();
      p3_op = OP_NOP;
      be = bus_q[0];
      vectors++; if (p4_misaligned !== 1'b0) begin miscompares++; $display("FAIL ld_misal %h: got %b want 0", addr, p4_misaligned); end
      vectors++; if (p4_mem_rdata !== exp_last) begin miscompares++; $display("FAIL ld_hold %h: got %h want %h", addr, p4_mem_rdata, exp_last); end
      for (int i = 0; i <= rdy_d; i++) begin
         vectors++; if ({dmem_request, dmem_write, p4_read_pending, p4_write_pending} !== 4'b1010) begin miscompares++; $display("FAIL ld_req %h cyc%0d: got %b want 1010", addr, i, {dmem_request, dmem_write, p4_read_pending, p4_write_pending}); end
         vectors++; if (dmem_addr !== be.addr || dmem_wstrb !== be.wstrb) begin miscompares++; $display("FAIL ld_bus %h cyc%0d: got %h/%b want %h/%b", addr, i, dmem_addr, dmem_wstrb, be.addr, be.wstrb); end
         if (i == rdy_d) begin
            dmem_ready = 1'b1;
         end else begin
            dmem_rvalid = 1'b1;
            dmem_rdata  = ~word;
         end
         tick();
         dmem_ready  = 1'b0;
         dmem_rvalid = 1'b0;
      end
      void'(bus_q.pop_front());
      for (int j = 0; j <= rv_d; j++) begin
         vectors++; if ({dmem_request, p4_read_pending} !== 2'b01) begin miscompares++; $display("FAIL ld_wait %h cyc%0d: got %b want 01", addr, j, {dmem_request, p4_read_pending}); end
         if (j == rv_d) begin
            dmem_rvalid = 1'b1;
            dmem_rdata  = word;
         end
         tick();
         dmem_rvalid = 1'b0;
         dmem_rdata  = 32'h5555_AAAA;
      end
      exp_last = data_q.pop_front();
      vectors++; if (p4_read_pending !== 1'b0) begin miscompares++; $display("FAIL ld_done %h: got %b want 0", addr, p4_read_pending); end
      vectors++; if (p4_mem_rdata !== exp_last) begin miscompares++; $display("FAIL ld_data %h: got %h want %h", addr, p4_mem_rdata, exp_last); end
      tick();
      vectors++; if (p4_mem_rdata !== exp_last) begin miscompares++; $display("FAIL ld_keep %h: got %h want %h", addr, p4_mem_rdata, exp_last); end
   endtask

   task automatic test_load_formats();
      run_load(OP_LDB,  32'h0000_0103, 32'h80FF_1234, 32'hFFFF_FF80, 0, 0);
      run_load(OP_LDBU, 32'h0000_0103, 32'h80FF_1234, 32'h0000_0080, 0, 0);
      run_load(OP_LDB,  32'h0000_0101, 32'h80FF_1234, 32'h0000_0012, 0, 0);
      run_load(OP_LDBU, 32'h0000_0102, 32'h80FF_1234, 32'h0000_00FF, 1, 0);
      run_load(OP_LDH,  32'h0000_0102, 32'h80FF_1234, 32'hFFFF_80FF, 0, 2);
      run_load(OP_LDHU, 32'h0000_0102, 32'h80FF_1234, 32'h0000_80FF, 0, 0);
      run_load(OP_LDH,  32'h0000_0100, 32'h80FF_1234, 32'h0000_1234, 0, 0);
      run_load(OP_LDH,  32'h0000_0104, 32'h0000_8001, 32'hFFFF_8001, 2, 1);
      run_load(OP_LDB,  32'h0000_0100, 32'h0000_00F0, 32'hFFFF_FFF0, 0, 0);
      run_load(OP_LDW,  32'h0000_0108, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 0);
   endtask

   task automatic run_store(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] wd,
                            input logic [31:0] exp_wd, input logic [3:0] exp_strb, input int rdy_d);
      bus_exp_t be;
      bus_q.push_back('{addr: {addr[31:2], 2'b00}, wdata: exp_wd, wstrb: exp_strb, write: 1'b1});
      p3_op     = op;
      p3_addr   = addr;
      p3_wdata  = wd;
      stall_drv = 1'b0;
      tick();
      p3_op = OP_NOP;
      be = bus_q[0];
      for (int i = 0; i <= rdy_d; i++) begin
         vectors++; if ({dmem_request, dmem_write, p4_read_pending, p4_write_pending} !== 4'b1101) begin miscompares++; $display("FAIL st_req %h cyc%0d: got %b want 1101", addr, i, {dmem_request, dmem_write, p4_read_pending, p4_write_pending}); end
         vectors++; if (dmem_addr !== be.addr || dmem_wdata !== be.wdata || dmem_wstrb !== be.wstrb) begin miscompares++; $display("FAIL st_bus %h cyc%0d: got %h/%h/%b want %h/%h/%b", addr, i, dmem_addr, dmem_wdata, dmem_wstrb, be.addr, be.wdata, be.wstrb); end
         if (i == rdy_d) dmem_ready = 1'b1;
         tick();
         dmem_ready = 1'b0;
      end
      void'(bus_q.pop_front());
      vectors++; if ({dmem_request, p4_write_pending} !== 2'b00) begin miscompares++; $display("FAIL st_done %h: got %b want 00", addr, {dmem_request, p4_write_pending}); end
      vectors++; if (p4_mem_rdata !== exp_last) begin miscompares++; $display("FAIL st_rdata %h: got %h want %h", addr, p4_mem_rdata, exp_last); end
   endtask

   task automatic test_store_formats();
      run_store(OP_STH, 32'h0000_0022, 32'h1234_ABCD, 32'hABCD_ABCD, 4'b1100, 3);
      run_store(OP_STB, 32'h0000_0031, 32'h0000_00A5, 32'hA5A5_A5A5, 4'b0010, 0);
      run_store(OP_STB, 32'h0000_0033, 32'hFFFF_FF5A, 32'h5A5A_5A5A, 4'b1000, 1);
      run_store(OP_STB, 32'h0000_0034, 32'h0000_0077, 32'h7777_7777, 4'b0001, 0);
      run_store(OP_STH, 32'h0000_0040, 32'hFFFF_1357, 32'h1357_1357, 4'b0011, 0);
      run_store(OP_STW, 32'h0000_0044, 32'hCAFE_F00D, 32'hCAFE_F00D, 4'b1111, 2);
   endtask

   task automatic test_misaligned();
      logic [5:0]  ops[3]   = '{OP_LDW, OP_LDH, OP_STW};
      logic [31:0] addrs[3] = '{32'h0000_0041, 32'h0000_0103, 32'h0000_0042};
      for (int k = 0; k < 3; k++) begin
         p3_op     = ops[k];
         p3_addr   = addrs[k];
         stall_drv = 1'b0;
         tick();
         p3_op = OP_NOP;
         stall_drv = 1'b1;
         exp_last  = 32'h0;
         for (int c = 0; c < 2; c++) begin
            vectors++; if ({dmem_request, p4_read_pending, p4_write_pending, p4_misaligned} !== 4'b0001) begin miscompares++; $display("FAIL misal[%0d] cyc%0d: got %b want 0001", k, c, {dmem_request, p4_read_pending, p4_write_pending, p4_misaligned}); end
            vectors++; if (p4_mem_rdata !== 32'h0) begin miscompares++; $display("FAIL misal_rdata[%0d]: got %h want 0", k, p4_mem_rdata); end
            tick();
         end
         stall_drv = 1'b0;
      end
      tick();
      vectors++; if (p4_misaligned !== 1'b0) begin miscompares++; $display("FAIL misal_clear: got %b want 0", p4_misaligned); end
   endtask

   task automatic test_back_to_back();
      use_pend  = 1'b1;
      stall_drv = 1'b0;
      data_q.push_back(32'h600D_F00D);
      p3_op   = OP_LDW;
      p3_addr = 32'h0000_0200;
      tick();
      p3_op    = OP_STW;
      p3_addr  = 32'h0000_0204;
      p3_wdata = 32'h1357_9BDF;
      bus_q.push_back('{addr: 32'h0000_0204, wdata: 32'h1357_9BDF, wstrb: 4'b1111, write: 1'b1});
      vectors++; if ({dmem_request, dmem_write, dmem_addr} !== {2'b10, 32'h0000_0200}) begin miscompares++; $display("FAIL b2b_ld_req: got %b%b %h want 10 00000200", dmem_request, dmem_write, dmem_addr); end
      dmem_ready = 1'b1;
      tick();
      dmem_ready = 1'b0;
      vectors++; if ({dmem_request, p4_read_pending} !== 2'b01) begin miscompares++; $display("FAIL b2b_wait: got %b want 01", {dmem_request, p4_read_pending}); end
      dmem_rvalid = 1'b1;
      dmem_rdata  = 32'h600D_F00D;
      tick();
      dmem_rvalid = 1'b0;
      exp_last = data_q.pop_front();
      vectors++; if ({dmem_request, p4_read_pending, p4_write_pending} !== 3'b000) begin miscompares++; $display("FAIL b2b_done: got %b want 000", {dmem_request, p4_read_pending, p4_write_pending}); end
      vectors++; if (p4_mem_rdata !== exp_last) begin miscompares++; $display("FAIL b2b_rdata: got %h want %h", p4_mem_rdata, exp_last); end
      tick();
      p3_op = OP_NOP;
      vectors++; if ({dmem_request, dmem_write, p4_write_pending} !== 3'b111) begin miscompares++; $display("FAIL b2b_st_req: got %b want 111", {dmem_request, dmem_write, p4_write_pending}); end
      vectors++; if (dmem_addr !== bus_q[0].addr || dmem_wdata !== bus_q[0].wdata || dmem_wstrb !== bus_q[0].wstrb) begin miscompares++; $display("FAIL b2b_st_bus: got %h/%h/%b want %h/%h/%b", dmem_addr, dmem_wdata, dmem_wstrb, bus_q[0].addr, bus_q[0].wdata, bus_q[0].wstrb); end
      dmem_ready = 1'b1;
      tick();
      dmem_ready = 1'b0;
      void'(bus_q.pop_front());
      vectors++; if ({dmem_request, p4_write_pending} !== 2'b00) begin miscompares++; $display("FAIL b2b_st_done: got %b want 00", {dmem_request, p4_write_pending}); end
      use_pend = 1'b0;
   endtask

   task automatic test_reset_mid_txn();
      stall_drv = 1'b0;
      p3_op     = OP_LDW;
      p3_addr   = 32'h0000_0300;
      tick();
      p3_op = OP_NOP;
      dmem_ready = 1'b1;
      tick();
      dmem_ready = 1'b0;
      vectors++; if (p4_read_pending !== 1'b1) begin miscompares++; $display("FAIL rmid_inwait: got %b want 1", p4_read_pending); end
      #2 reset = 1'b1;
      #1;
      exp_last = 32'h0;
      vectors++; if ({dmem_request, dmem_write, p4_read_pending, p4_write_pending, p4_misaligned} !== 5'b0) begin miscompares++; $display("FAIL rmid_flags: got %b want 00000", {dmem_request, dmem_write, p4_read_pending, p4_write_pending, p4_misaligned}); end
      vectors++; if ({dmem_addr, dmem_wstrb, p4_mem_rdata} !== 68'h0) begin miscompares++; $display("FAIL rmid_data: got %h %b %h want zeros", dmem_addr, dmem_wstrb, p4_mem_rdata); end
      tick();
      reset = 1'b0;
      dmem_rvalid = 1'b1;
      dmem_rdata  = 32'hFFFF_FFFF;
      tick();
      dmem_rvalid = 1'b0;
      tick();
      vectors++; if (p4_mem_rdata !== exp_last) begin miscompares++; $display("FAIL rmid_late_rvalid: got %h want %h", p4_mem_rdata, exp_last); end
      vectors++; if ({dmem_request, p4_read_pending, p4_write_pending} !== 3'b000) begin miscompares++; $display("FAIL rmid_after: got %b want 000", {dmem_request, p4_read_pending, p4_write_pending}); end
   endtask

   initial begin
      test_reset();
      test_non_mem_op();
      test_load_formats();
      test_store_formats();
      test_misaligned();
      test_back_to_back();
      test_reset_mid_txn();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
